// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_pkg : shared UART widths, FIFO depth and status bit indices |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    // Bit positions inside the APB status register.
    localparam int RX_EMPTY_BIT = 0;
    localparam int RX_FULL_BIT  = 1;
    localparam int RX_OVR_BIT   = 2;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_fifo_mem : DEPTH x WIDTH storage, sync write / async read   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);

    // Deliberately unreset so the array maps onto plain register/LUT RAM.
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | uart_rx_fifo : FWFT receive FIFO with occupancy and sticky overrun|
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       rx_data,
    input  logic                   rx_done,
    input  logic                   rd_en,
    input  logic                   clr_overrun,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overrun
);

    localparam int                PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]    FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [WIDTH-1:0] mem_rdata;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a byte then.
    assign do_pop  = rd_en & ~empty;
    assign do_push = rx_done & (~full | do_pop);

    assign empty   = (count == '0);
    assign full    = (count == FULL_COUNT);
    assign rd_data = empty ? '0 : mem_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (do_pop && !do_push) begin
                count <= count - (PTR_W + 1)'(1);
            end
            // A dropped byte outranks a simultaneous clear.
            if (rx_done && !do_push) begin
                overrun <= 1'b1;
            end else if (clr_overrun) begin
                overrun <= 1'b0;
            end
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_push),
        .waddr (wr_ptr),
        .wdata (rx_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_uart_rx_fifo : directed scoreboard bench for uart_rx_fifo     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] rx_data;
    logic             rx_done;
    logic             rd_en;
    logic             clr_overrun;
    logic [WIDTH-1:0] rd_data;
    logic             empty;
    logic             full;
    logic [4:0]       count;
    logic             overrun;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb [$];
    bit         m_ovr;

    always #5 clk = ~clk;

    uart_rx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .rd_en       (rd_en),
        .clr_overrun (clr_overrun),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .overrun     (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag);
        logic [7:0] exp_rd;
        exp_rd = (sb.size() > 0) ? sb[0] : 8'h00;
        check({tag, "_count"},   32'(count),   32'(sb.size()));
        check({tag, "_empty"},   32'(empty),   32'(sb.size() == 0));
        check({tag, "_full"},    32'(full),    32'(sb.size() == DEPTH));
        check({tag, "_overrun"}, 32'(overrun), 32'(m_ovr));
        check({tag, "_rd_data"}, 32'(rd_data), 32'(exp_rd));
    endtask

    // One clock of stimulus; the scoreboard is updated with what the FIFO should do.
    task automatic cycle(input bit push, input logic [7:0] d, input bit pop, input bit clr);
        bit m_pop;
        bit m_push;
        m_pop  = pop && (sb.size() > 0);
        m_push = push && ((sb.size() < DEPTH) || m_pop);
        if (m_pop) check("pop_data", 32'(rd_data), 32'(sb[0]));
        if (push && !m_push) m_ovr = 1'b1;
        else if (clr) m_ovr = 1'b0;
        rx_done     = push;
        rx_data     = d;
        rd_en       = pop;
        clr_overrun = clr;
        @(posedge clk);
        #1;
        rx_done     = 1'b0;
        rd_en       = 1'b0;
        clr_overrun = 1'b0;
        if (m_pop) void'(sb.pop_front());
        if (m_push) sb.push_back(d);
    endtask

    // Reset cycle with a push and pop also asserted, both of which must be ignored.
    task automatic do_reset();
        rst     = 1'b1;
        rx_done = 1'b1;
        rx_data = 8'hEE;
        rd_en   = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rx_done = 1'b0;
        rd_en   = 1'b0;
        sb.delete();
        m_ovr = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] last;
        rst = 1'b1; rx_data = '0; rx_done = 1'b0; rd_en = 1'b0; clr_overrun = 1'b0;
        m_ovr = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset values and pop-while-empty
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        cycle(0, 8'h00, 1, 0);
        check_status("empty_pop");

        // Two bytes, 20 cycles apart
        cycle(1, 8'hA5, 0, 0);
        check("first_rd_data", 32'(rd_data), 32'hA5);
        for (int i = 0; i < 19; i++) cycle(0, 8'h00, 0, 0);
        cycle(1, 8'h3C, 0, 0);
        check("two_count", 32'(count), 32'd2);
        check("two_rd_data", 32'(rd_data), 32'hA5);
        cycle(0, 8'h00, 1, 0);
        check("pop1_rd_data", 32'(rd_data), 32'h3C);
        check("pop1_count", 32'(count), 32'd1);
        cycle(0, 8'h00, 1, 0);
        check("pop2_empty", 32'(empty), 32'd1);
        check("pop2_rd_data", 32'(rd_data), 32'h00);

        // Fill, overflow, drain
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 0);
        check("fill_full", 32'(full), 32'd1);
        check("fill_count", 32'(count), 32'd16);
        cycle(1, 8'hFF, 0, 0);
        check("ovr_flag", 32'(overrun), 32'd1);
        check("ovr_count", 32'(count), 32'd16);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(rd_data), 32'(i));
            cycle(0, 8'h00, 1, 0);
        end
        check_status("drained");
        cycle(0, 8'h00, 0, 1);
        check("clr_overrun", 32'(overrun), 32'd0);

        // Simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h10 + i), 0, 0);
        cycle(1, 8'h77, 1, 0);
        check("full_pp_count", 32'(count), 32'd16);
        check("full_pp_overrun", 32'(overrun), 32'd0);
        last = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            last = rd_data;
            cycle(0, 8'h00, 1, 0);
        end
        check("full_pp_last", 32'(last), 32'h77);
        check_status("full_pp_drained");

        // Pointer wrap with interleaved push/pop
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            cycle(1, d, 0, 0);
            check("wrap_count_le1", 32'(count <= 5'd1), 32'd1);
            cycle(0, 8'h00, 1, 0);
        end
        check_status("wrap_end");

        // Set beats clear
        for (int i = 0; i < DEPTH; i++) cycle(1, 8'(8'h40 + i), 0, 0);
        cycle(1, 8'hAA, 0, 0);
        check("ovr_set", 32'(overrun), 32'd1);
        cycle(1, 8'hBB, 0, 1);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        cycle(0, 8'h00, 0, 1);
        check("ovr_cleared", 32'(overrun), 32'd0);
        check_status("ovr_seq");

        // Mid-fill reset
        for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 0);
        for (int i = 0; i < 3; i++) cycle(1, 8'(8'h90 + i), 0, 0);
        do_reset();
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_full", 32'(full), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        check("midrst_rd_data", 32'(rd_data), 32'h00);
        cycle(1, 8'h5A, 0, 0);
        check("post_rst_rd_data", 32'(rd_data), 32'h5A);
        cycle(0, 8'h00, 1, 0);
        check_status("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer sitting directly downstream of the UART receiver in the APB UART peripheral. Each completed byte (`rx_data` qualified by the one-cycle `rx_done` pulse) is captured into a circular FIFO. Data is held until the APB register front-end pops it. The block reports empty/full/occupancy and a sticky overrun flag, so the CPU can drain bursts without losing bytes.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥ 2.
- `WIDTH`, 8: data width; matches the UART data width.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: synchronous, active-high reset.
- `rx_data` in WIDTH: byte from the UART receiver; sampled only when `rx_done`=1.
- `rx_done` in 1: push strobe; one-cycle pulse per received byte.
- `rd_en` in 1: pop strobe from the APB front-end.
- `clr_overrun` in 1: clears the sticky overrun flag.
- `rd_data` out WIDTH: head entry, first-word-fall-through.
- `empty` out 1: FIFO holds 0 entries.
- `full` out 1: FIFO holds DEPTH entries.
- `count` out $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overrun` out 1: sticky; a byte was dropped because the FIFO was full.

## Operation
- Storage:
  - DEPTH×WIDTH array.
  - Write pointer `wr_ptr` and read pointer `rd_ptr` are each $clog2(DEPTH) bits, with natural wrap DEPTH-1 → 0.
  - Occupancy is tracked by an explicit `count` register. `empty` = (count==0), `full` = (count==DEPTH), both decoded from `count`.
- Effective events per cycle:
  - `do_pop` = `rd_en` & !`empty`.
  - `do_push` = `rx_done` & (!`full` | `do_pop`).
- Push: writes `rx_data` at `wr_ptr`, then `wr_ptr`+1.
- Pop: `rd_ptr`+1.
- Count update:
  - push only: +1.
  - pop only: −1.
  - both or neither: unchanged.
- Boundary cases:
  - Pop when empty: ignored. No pointer, count or flag change.
  - Push and pop while empty: push only, since `do_pop`=0. Count becomes 1.
  - Push and pop while full: both occur, count stays DEPTH. The new byte lands in the slot freed by the pop.
  - Push while full without pop: byte dropped. Pointers and count unchanged; `overrun` ← 1.
  - `clr_overrun` with no overrun event: `overrun` ← 0. If an overrun event occurs in the same cycle, set wins and `overrun` stays 1.
- `rd_data`:
  - = mem[`rd_ptr`] when !`empty`.
  - = '0 when `empty`. Deterministic even though the array itself is not reset.
- Reset mid-operation: contents discarded. Pointers and count go to 0; any in-flight push or pop in the reset cycle is ignored.

## Timing
- Reset values: `count`=0, `empty`=1, `full`=0, `overrun`=0, `rd_data`=0.
- Push latency: `rx_done` high in cycle N → from cycle N+1, `empty`=0 and `count` incremented. If the FIFO was empty, `rd_data` shows the new byte in N+1.
- Pop: `rd_en` in cycle N consumes the byte visible on `rd_data` during N. From N+1, `rd_data` presents the next entry, or 0 if now empty.
- No combinational path from `rd_en`/`rx_done` to `empty`/`full`/`count`; all three are registered. `rd_data` is an asynchronous read of the registered `rd_ptr`.
- Throughput: one push and one pop per cycle sustained.

## Structure
- Shared package `uart_pkg` holds:
  - `UART_DATA_W` = 8.
  - `UART_RX_FIFO_DEPTH` = 16 (default for instantiation).
  - The status bit-position constants used by the APB status register: `RX_EMPTY_BIT`, `RX_FULL_BIT`, `RX_OVR_BIT`.
- One sub-module, `uart_fifo_mem`: DEPTH×WIDTH storage with synchronous write and asynchronous read, and no reset. Pointer/count control stays in `uart_rx_fifo`. The later TX FIFO reuses `uart_fifo_mem`.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `count`=0, `overrun`=0, `rd_data`=8'h00. A `rd_en` pulse leaves everything unchanged.
- Push 8'hA5, then 8'h3C (one `rx_done` each, 20 cycles apart) → `count`=2, `rd_data`=8'hA5. Pop → `rd_data`=8'h3C, `count`=1. Pop → `empty`=1, `rd_data`=8'h00.
- Push 16 bytes 8'h00..8'h0F → `full`=1, `count`=16. Push 8'hFF → `overrun`=1, `count`=16. Drain all 16 → values 8'h00..8'h0F in order; 8'hFF absent.
- Full FIFO, same-cycle `rx_done` (8'h77) + `rd_en` → `count` stays 16, `overrun` stays 0. After 16 pops, the last byte read is 8'h77.
- Pointer wrap: 40 interleaved push/pop pairs with random data → scoreboard matches; `count` never exceeds 1.
- `overrun`=1, assert `clr_overrun` together with a full-push → `overrun` stays 1. Next cycle `clr_overrun` alone → 0. Mid-fill `rst` → all outputs at reset values one cycle later.
